// File: rtl/uart_char_receiver_if.sv
// rtl/uart_char_receiver_if.sv - serial line and character output bundle of the UART receiver
//
// Purpose : groups the serial input with the received-character outputs.
// Signals : rx        - serial line, idle high, 8N1, LSB first
//           cin       - last correctly framed byte
//           we        - one-clk pulse marking a new byte on cin
//           frame_err - one-clk pulse on a bad stop bit
//           busy      - receiver is inside a frame
// Modports: master - the receiver (consumes rx, drives the rest)
//           slave  - the line driver / character consumer
interface uart_char_receiver_if;
  logic       rx;
  logic [7:0] cin;
  logic       we;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output cin, output we, output frame_err, output busy);
  modport slave  (output rx, input cin, input we, input frame_err, input busy);
endinterface

// File: rtl/uart_char_receiver.sv
// rtl/uart_char_receiver.sv - 8N1 UART receiver with 16x oversampling
//
// Purpose : receives 8N1 characters on bus.rx and presents each correctly
//           framed byte on bus.cin with a one-clk bus.we pulse; a low stop
//           bit gives one bus.frame_err pulse and the receiver then waits
//           for the line to return high.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous, active-high
//           bus   - uart_char_receiver_if.master (rx, cin, we, frame_err, busy)
module uart_char_receiver #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input logic                   clk,
  input logic                   reset,
  uart_char_receiver_if.master  bus
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t             state, state_n;
  logic [3:0]         sc, sc_n;
  logic [2:0]         bi, bi_n;
  logic [7:0]         sr, sr_n;
  logic [7:0]         cin, cin_n;
  logic               we, we_n;
  logic               frame_err, fe_n;
  logic               div_clr;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               rx_meta, rxs;

  // Synchronizer presets to 1 so reset looks like an idle line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // Oversample divider; realigned to the start edge so that the first
  // tick lands DIV clks after the falling edge was seen.
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sc        <= 4'd0;
      bi        <= 3'd0;
      sr        <= 8'h00;
      cin       <= 8'h00;
      we        <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      sc        <= sc_n;
      bi        <= bi_n;
      sr        <= sr_n;
      cin       <= cin_n;
      we        <= we_n;
      frame_err <= fe_n;
    end
  end

  // sc wraps 15->0 on its own, so a tick at sc=15 leaves it at 0 for the
  // next bit. START samples at sc=7 (middle of the start bit); every later
  // sample is 16 ticks on, i.e. the middle of each following bit.
  always_comb begin
    state_n = state;
    sc_n    = sc;
    bi_n    = bi;
    sr_n    = sr;
    cin_n   = cin;
    we_n    = 1'b0;
    fe_n    = 1'b0;
    div_clr = 1'b0;

    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          sc_n    = 4'd0;
          div_clr = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == 4'd7) begin
            if (!rxs) begin
              state_n = DATA;
              sc_n    = 4'd0;
              bi_n    = 3'd0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end

      DATA: begin
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == 4'd15) begin
            sr_n = {rxs, sr[7:1]};
            if (bi == 3'd7) begin
              state_n = STOP;
            end else begin
              bi_n = bi + 3'd1;
            end
          end
        end
      end

      STOP: begin
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == 4'd15) begin
            if (rxs) begin
              cin_n   = sr;
              we_n    = 1'b1;
              state_n = IDLE;
            end else begin
              fe_n    = 1'b1;
              state_n = WAIT_HIGH;
            end
          end
        end
      end

      // A break holds the line low; stay here so it reports only once.
      WAIT_HIGH: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.cin       = cin;
  assign bus.we        = we;
  assign bus.frame_err = frame_err;
  assign bus.busy      = (state != IDLE);

endmodule
